scanline_fx: RTL and testbench

Parametrised scanline generator for the video output path. It sits between the core's RGB output and the scaler/analog video mux. It darkens selected lines with a configurable attenuation level, a configurable line period and optional per-frame phase alternation. Settings are latched once per frame, so a menu change never tears mid-frame. Sync, enable and strobe signals are delayed by the same fixed latency as the pixel data.

---
 rtl/scanline_pkg.sv | 19 +
 rtl/scanline_dim.sv | 30 +++
 rtl/scanline_fx.sv | 122 ++++++++++++
 tb/tb_scanline_fx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/scanline_pkg.sv
`timescale 1ns/1ps
// Shared constants and helpers for the scanline effect.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package scanline_pkg;

    // Attenuation level encodings; 5..7 behave like LVL_OFF.
    localparam logic [2:0] LVL_OFF   = 3'd0;
    localparam logic [2:0] LVL_25    = 3'd1;
    localparam logic [2:0] LVL_50    = 3'd2;
    localparam logic [2:0] LVL_75    = 3'd3;
    localparam logic [2:0] LVL_BLACK = 3'd4;

    // A dimming group needs at least two lines, so 0 and 1 become 2.
    function automatic int unsigned eff_period(input int unsigned p);
        return (p < 2) ? 32'd2 : p;
    endfunction

endpackage

// File: rtl/scanline_dim.sv
`timescale 1ns/1ps
// Per-channel attenuator: scales one colour component by the selected level.
// Latency: combinational.
// Backpressure: none.
module scanline_dim
    import scanline_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] c_in,
    input  logic [2:0]    level,
    input  logic          dim,
    output logic [CW-1:0] c_out
);

    // Shift-based scaling; the -25% sum is at most c, so it never overflows CW bits.
    always_comb begin
        c_out = c_in;
        if (dim) begin
            case (level)
                LVL_25:    c_out = (c_in >> 1) + (c_in >> 2);
                LVL_50:    c_out = c_in >> 1;
                LVL_75:    c_out = c_in >> 2;
                LVL_BLACK: c_out = '0;
                default:   c_out = c_in;
            endcase
        end
    end

endmodule

// File: rtl/scanline_fx.sv
`timescale 1ns/1ps
// Scanline generator: darkens every per-th line, settings latched at frame start.
// Latency: LAT clocks for pixel, line_dim and all sync/strobe outputs alike.
// Backpressure: none; free-running video path, ce is only delayed.
module scanline_fx
    import scanline_pkg::*;
#(
    parameter int CW  = 8,
    parameter int PW  = 3,
    parameter int LAT = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      level,
    input  logic [PW-1:0]   period,
    input  logic            alternate,
    input  logic [3*CW-1:0] din,
    input  logic            hs_in,
    input  logic            vs_in,
    input  logic            de_in,
    input  logic            ce_in,
    output logic [3*CW-1:0] dout,
    output logic            hs_out,
    output logic            vs_out,
    output logic            de_out,
    output logic            ce_out,
    output logic            line_dim
);

    localparam int SW = 3*CW + 5;

    logic          old_hs_q, old_hs_d;
    logic          old_vs_q, old_vs_d;
    logic [2:0]    lvl_l_q,  lvl_l_d;
    logic [PW-1:0] per_l_q,  per_l_d;
    logic          alt_l_q,  alt_l_d;
    logic [PW-1:0] cnt_q,    cnt_d;
    logic          ph_q,     ph_d;
    logic [SW-1:0] pipe_q [LAT];
    logic [SW-1:0] pipe_d [LAT];

    logic          line_edge, frame_edge, dim;
    logic [PW-1:0] per_m1, dim_line;
    logic [3*CW-1:0] pix_att;

    // Sync edge detection and the dim decision for the current pixel (old state).
    always_comb begin
        line_edge  = old_hs_q & ~hs_in;
        frame_edge = old_vs_q & ~vs_in;
        per_m1     = per_l_q - PW'(1);
        dim_line   = (alt_l_q & ph_q) ? '0 : per_m1;
        dim        = (lvl_l_q != LVL_OFF) && (cnt_q == dim_line);
    end

    // One attenuator per colour channel, R in the top bits.
    for (genvar g = 0; g < 3; g++) begin : g_ch
        scanline_dim #(.CW(CW)) u_dim (
            .c_in  (din[g*CW +: CW]),
            .level (lvl_l_q),
            .dim   (dim),
            .c_out (pix_att[g*CW +: CW])
        );
    end

    // Next state: frame edge reloads settings and wins over a coincident line edge.
    always_comb begin
        old_hs_d = hs_in;
        old_vs_d = vs_in;
        lvl_l_d  = lvl_l_q;
        per_l_d  = per_l_q;
        alt_l_d  = alt_l_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        if (frame_edge) begin
            lvl_l_d = level;
            per_l_d = PW'(eff_period(32'(period)));
            alt_l_d = alternate;
            cnt_d   = '0;
            ph_d    = alternate ? ~ph_q : 1'b0;
        end else if (line_edge) begin
            cnt_d = (cnt_q == per_m1) ? '0 : cnt_q + PW'(1);
        end
    end

    // Delay line carrying the processed pixel alongside its sync and strobe bits.
    always_comb begin
        pipe_d[0] = {pix_att, dim, hs_in, vs_in, de_in, ce_in};
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State registers; settings default to an undimmed period-2 setup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            old_hs_q <= 1'b0;
            old_vs_q <= 1'b0;
            lvl_l_q  <= LVL_OFF;
            per_l_q  <= PW'(2);
            alt_l_q  <= 1'b0;
            cnt_q    <= '0;
            ph_q     <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            old_hs_q <= old_hs_d;
            old_vs_q <= old_vs_d;
            lvl_l_q  <= lvl_l_d;
            per_l_q  <= per_l_d;
            alt_l_q  <= alt_l_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign {dout, line_dim, hs_out, vs_out, de_out, ce_out} = pipe_q[LAT-1];

endmodule

// File: tb/tb_scanline_fx.sv
`timescale 1ns/1ps
// Bench for scanline_fx: frame-level stimulus, line-index reference model, cycle-tagged scoreboard.
// Latency: expected values fall due LAT clocks after the vector is driven.
// Backpressure: none.
module tb_scanline_fx;

    localparam int CW  = 8;
    localparam int PW  = 3;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [2:0]      level;
    logic [PW-1:0]   period;
    logic            alternate;
    logic [3*CW-1:0] din;
    logic            hs_in, vs_in, de_in, ce_in;
    logic [3*CW-1:0] dout;
    logic            hs_out, vs_out, de_out, ce_out, line_dim;

    scanline_fx #(.CW(CW), .PW(PW), .LAT(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .level     (level),
        .period    (period),
        .alternate (alternate),
        .din       (din),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .de_in     (de_in),
        .ce_in     (ce_in),
        .dout      (dout),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .de_out    (de_out),
        .ce_out    (ce_out),
        .line_dim  (line_dim)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [23:0] pix;
        logic        dim, hs, vs, de, ce;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc++;

    // Reference model state: settings seen at the last frame start and the
    // number of lines since then (dimming is a modulo of that line index).
    logic m_old_hs, m_old_vs;
    int   m_lvl, m_per, m_line;
    bit   m_alt, m_ph;

    task automatic model_reset();
        m_old_hs = 0; m_old_vs = 0;
        m_lvl = 0; m_per = 2; m_alt = 0; m_ph = 0; m_line = 0;
    endtask

    function automatic logic [23:0] atten(input logic [23:0] p, input int lvl);
        logic [23:0] r;
        for (int k = 0; k < 3; k++) begin
            int c;
            int o;
            c = int'(p[k*8 +: 8]);
            case (lvl)
                1:       o = c/2 + c/4;
                2:       o = c/2;
                3:       o = c/4;
                4:       o = 0;
                default: o = c;
            endcase
            r[k*8 +: 8] = 8'(o);
        end
        return r;
    endfunction

    // Drive one vector, predict its output and schedule it LAT clocks ahead.
    task automatic drive(input logic hs, input logic vs, input logic de,
                         input logic ce, input logic [23:0] px);
        exp_t x;
        bit   d;
        int   tgt;
        @(posedge clk); #1;
        hs_in = hs; vs_in = vs; de_in = de; ce_in = ce; din = px;
        tgt = (m_alt && m_ph) ? 0 : m_per - 1;
        d   = (m_lvl != 0) && ((m_line % m_per) == tgt);
        x.due = cyc + LAT;
        x.pix = d ? atten(px, m_lvl) : px;
        x.dim = d; x.hs = hs; x.vs = vs; x.de = de; x.ce = ce;
        sb.push_back(x);
        if (m_old_vs && !vs) begin
            m_line = 0;
            m_lvl  = int'(level);
            m_per  = (int'(period) < 2) ? 2 : int'(period);
            m_alt  = alternate;
            m_ph   = alternate ? !m_ph : 1'b0;
        end else if (m_old_hs && !hs) begin
            m_line++;
        end
        m_old_hs = hs; m_old_vs = vs;
    endtask

    // One frame: vsync pulse (optionally with hsync falling alongside), then lines.
    task automatic frame(input int lvl, input int per, input bit alt, input int nlines,
                         input bit coinc, input bit rnd, input logic [23:0] px, input int mid_lvl);
        level = 3'(lvl); period = PW'(per); alternate = alt;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        drive(coinc, 1'b1, 1'b0, 1'b0, 24'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        for (int l = 0; l < nlines; l++) begin
            int npx;
            npx = $urandom_range(2, 4);
            if (l == nlines/2 && mid_lvl >= 0) begin
                level = 3'(mid_lvl);
                period = PW'($urandom_range(0, 7));
                alternate = ~alternate;
            end
            for (int p = 0; p < npx; p++)
                drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd ? 24'($urandom) : px);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        end
    endtask

    // Reset asserted mid-cycle: outputs must drop at once, then the pipeline refills.
    task automatic reset_mid();
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        n_vec++;
        if ({dout, line_dim, hs_out, vs_out, de_out, ce_out} !== '0) begin
            n_err++;
            $display("FAIL async_reset: outputs %h/%b%b%b%b%b, required all zero",
                     dout, line_dim, hs_out, vs_out, de_out, ce_out);
        end
        hs_in = 0; vs_in = 0; de_in = 0; ce_in = 0; din = '0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    // Monitor: pop whatever falls due this cycle; zero outputs while in reset.
    always @(negedge clk) begin
        if (!reset_n) begin
            if (cyc > 0) begin
                n_vec++;
                if ({dout, line_dim, hs_out, vs_out, de_out, ce_out} !== '0) begin
                    n_err++;
                    $display("FAIL in_reset cyc=%0d: outputs %h/%b, required zero", cyc, dout, line_dim);
                end
            end
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL stale cyc=%0d: entry due %0d never compared", cyc, e.due);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if ({dout, line_dim, hs_out, vs_out, de_out, ce_out} !==
                    {e.pix, e.dim, e.hs, e.vs, e.de, e.ce}) begin
                    n_err++;
                    $display("FAIL pixel cyc=%0d: got dout=%h dim=%b hs/vs/de/ce=%b%b%b%b, required dout=%h dim=%b hs/vs/de/ce=%b%b%b%b",
                             cyc, dout, line_dim, hs_out, vs_out, de_out, ce_out,
                             e.pix, e.dim, e.hs, e.vs, e.de, e.ce);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        level = 0; period = 0; alternate = 0;
        din = '0; hs_in = 0; vs_in = 0; de_in = 0; ce_in = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Defaults before any frame edge, then the basic period-2 case.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 24'hFF8040);
        frame(2, 2, 0, 6, 0, 0, 24'hFF8040, -1);
        // Level sweep on a white field, including an out-of-range level.
        frame(1, 2, 0, 4, 0, 0, 24'hFFFFFF, -1);
        frame(4, 2, 0, 4, 0, 0, 24'hFFFFFF, -1);
        frame(6, 2, 0, 4, 0, 0, 24'hFFFFFF, -1);
        // Period 3 with alternation over three frames.
        for (int f = 0; f < 3; f++) frame(2, 3, 1, 9, 0, 1, 24'h0, -1);
        // Mid-frame level change 0 -> 3 takes effect only from the next frame.
        frame(0, 2, 0, 6, 0, 1, 24'h0, 3);
        frame(3, 2, 0, 6, 0, 1, 24'h0, -1);
        // Coincident hsync/vsync falling edges.
        frame(2, 2, 0, 4, 1, 1, 24'h0, -1);
        // Reset in the middle of a line, then resume.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 24'($urandom));
        reset_mid();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 24'($urandom));
        frame(2, 2, 0, 4, 0, 1, 24'h0, -1);
        // Randomised frames, some with mid-frame setting churn.
        for (int f = 0; f < 24; f++)
            frame($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  $urandom_range(3, 10), 1'($urandom_range(0, 1)), 1'b1, 24'h0,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1);

        repeat (LAT + 2) @(posedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
